// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract sequencer: a TOTAL_W-bit A+B or A-B computed one
// SLICE_W-bit slice per clock, LSB first, through a single shared add/sub slice.
module mw_addsub_seq #(
    parameter  int SLICE_W = 4,
    parameter  int NSLICES = 4,
    localparam int TOTAL_W = SLICE_W * NSLICES,
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic [TOTAL_W-1:0] a_in,
    input  logic [TOTAL_W-1:0] b_in,
    input  logic               control_in,
    output logic               ready_out,
    output logic               busy_out,
    output logic               done_out,
    output logic [TOTAL_W-1:0] sum_out,
    output logic               carry_out,
    output logic               overflow_out,
    output logic [1:0]         dbg_state_out
);

    // Handshake: a request is taken on a rising edge where start_in=1 and
    // ready_out=1; operands are captured on that edge only. done_out is a
    // one-cycle pulse marking sum_out/carry_out/overflow_out as fresh; start_in
    // seen while busy_out=1 is dropped, never queued.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [TOTAL_W-1:0] a_q, a_d;
    logic [TOTAL_W-1:0] b_q, b_d;
    logic               ctrl_q, ctrl_d;
    logic [TOTAL_W-1:0] res_q, res_d;
    logic [TOTAL_W-1:0] sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               c_sl;

    // Shared slice: B is inverted for subtract, the +1 enters as the initial carry.
    always_comb begin
        a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
        b_sl = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{ctrl_q}};
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    ctrl_d  = control_in;
                    carry_d = control_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[idx_q*SLICE_W +: SLICE_W] = s_sl;
                carry_d = c_sl;
                if (idx_q == IDX_W'(NSLICES - 1)) begin
                    // Publish the whole word at once so outputs never show partial slices.
                    state_d = ST_DONE;
                    idx_d   = '0;
                    sum_d   = res_d;
                    cout_d  = c_sl;
                    ovf_d   = (a_q[TOTAL_W-1] == (b_q[TOTAL_W-1] ^ ctrl_q)) &&
                              (s_sl[SLICE_W-1] != a_q[TOTAL_W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_out     = (state_q == ST_IDLE);
    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = (state_q == ST_DONE);
    assign sum_out       = sum_q;
    assign carry_out     = cout_q;
    assign overflow_out  = ovf_q;
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_mw_addsub_seq.sv
// Bench for mw_addsub_seq: directed cases followed by random operations, all
// compared against an integer-arithmetic model of a 16-bit add/subtract.
module tb_mw_addsub_seq;

    localparam int SLICE_W = 4;
    localparam int NSLICES = 4;
    localparam int TW      = SLICE_W * NSLICES;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start_in;
    logic [TW-1:0] a_in, b_in;
    logic          control_in;
    logic          ready_out, busy_out, done_out;
    logic [TW-1:0] sum_out;
    logic          carry_out, overflow_out;
    logic [1:0]    dbg_state_out;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] prev_sum;
    logic          prev_c, prev_o;

    mw_addsub_seq #(.SLICE_W(SLICE_W), .NSLICES(NSLICES)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .control_in    (control_in),
        .ready_out     (ready_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .sum_out       (sum_out),
        .carry_out     (carry_out),
        .overflow_out  (overflow_out),
        .dbg_state_out (dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

    // Advance to 1ns after the next rising edge; outputs are stable there.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
    function automatic void model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ctrl,
                                  output logic [TW-1:0] s, output logic c, output logic o);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!ctrl) begin
            ur = ua + ub;
            c  = (ur > 65535);
            sr = sa + sb;
        end else begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end
        s = ur[TW-1:0];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic scramble();
        a_in       = TW'($urandom_range(0, 65535));
        b_in       = TW'($urandom_range(0, 65535));
        control_in = 1'($urandom_range(0, 1));
    endtask

    // Full operation from the accept edge E0 to the return to IDLE at E(NSLICES+1).
    // With noise=1, start_in stays high with junk operands for the whole operation.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ctrl,
                          input logic noise, input string tag);
        logic [TW-1:0] es;
        logic          ec, eo;
        model(a, b, ctrl, es, ec, eo);
        chk({tag, " ready_before"}, 32'(ready_out), 32'd1);
        start_in   = 1'b1;
        a_in       = a;
        b_in       = b;
        control_in = ctrl;
        tick();
        start_in = noise;
        scramble();
        for (int k = 1; k < NSLICES; k++) begin
            tick();
            chk({tag, " busy_run"},  32'(busy_out),  32'd1);
            chk({tag, " ready_run"}, 32'(ready_out), 32'd0);
            chk({tag, " done_run"},  32'(done_out),  32'd0);
            chk({tag, " sum_hold"},  32'(sum_out),   32'(prev_sum));
            chk({tag, " c_hold"},    32'(carry_out), 32'(prev_c));
            chk({tag, " o_hold"},    32'(overflow_out), 32'(prev_o));
            if (noise) scramble();
        end
        tick();
        chk({tag, " done_pulse"}, 32'(done_out),     32'd1);
        chk({tag, " busy_done"},  32'(busy_out),     32'd1);
        chk({tag, " sum"},        32'(sum_out),      32'(es));
        chk({tag, " carry"},      32'(carry_out),    32'(ec));
        chk({tag, " overflow"},   32'(overflow_out), 32'(eo));
        if (noise) scramble();
        tick();
        chk({tag, " done_end"},  32'(done_out),  32'd0);
        chk({tag, " ready_end"}, 32'(ready_out), 32'd1);
        chk({tag, " busy_end"},  32'(busy_out),  32'd0);
        chk({tag, " sum_keep"},  32'(sum_out),   32'(es));
        start_in = 1'b0;
        prev_sum = es;
        prev_c   = ec;
        prev_o   = eo;
    endtask

    logic [TW-1:0] corner [4];

    initial begin
        corner[0] = 16'h0000;
        corner[1] = 16'hFFFF;
        corner[2] = 16'h8000;
        corner[3] = 16'h7FFF;
        prev_sum   = '0;
        prev_c     = 1'b0;
        prev_o     = 1'b0;
        rst_n_in   = 1'b0;
        start_in   = 1'b1;
        a_in       = 16'h1234;
        b_in       = 16'h0001;
        control_in = 1'b0;

        // Reset held for two edges with start_in high: nothing accepted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst ready",    32'(ready_out),    32'd1);
            chk("rst busy",     32'(busy_out),     32'd0);
            chk("rst done",     32'(done_out),     32'd0);
            chk("rst sum",      32'(sum_out),      32'h0000);
            chk("rst carry",    32'(carry_out),    32'd0);
            chk("rst overflow", 32'(overflow_out), 32'd0);
        end
        rst_n_in = 1'b1;
        start_in = 1'b0;
        tick();
        chk("post_rst ready", 32'(ready_out), 32'd1);
        chk("post_rst done",  32'(done_out),  32'd0);

        // Directed arithmetic cases.
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "add_1234_0fcd");
        chk("lit sum_2201", 32'(sum_out), 32'h2201);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ffff_0001");
        chk("lit carry_ripple", 32'(carry_out), 32'd1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_7fff_0001");
        chk("lit ovf_8000", 32'(overflow_out), 32'd1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_0005_0007");
        chk("lit sum_fffe", 32'(sum_out), 32'hFFFE);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_8000_0001");
        chk("lit sum_7fff", 32'(sum_out), 32'h7FFF);

        // start_in held high with changing operands during RUN/DONE is ignored.
        run_op(16'h0100, 16'h0200, 1'b0, 1'b1, "noise_0100_0200");
        chk("lit sum_0300", 32'(sum_out), 32'h0300);

        // Reset landing on E2 aborts the operation.
        start_in   = 1'b1;
        a_in       = 16'h4321;
        b_in       = 16'h1111;
        control_in = 1'b0;
        tick();
        start_in = 1'b0;
        tick();
        rst_n_in = 1'b0;
        tick();
        chk("abort ready",    32'(ready_out),    32'd1);
        chk("abort busy",     32'(busy_out),     32'd0);
        chk("abort sum",      32'(sum_out),      32'h0000);
        chk("abort carry",    32'(carry_out),    32'd0);
        chk("abort overflow", 32'(overflow_out), 32'd0);
        rst_n_in = 1'b1;
        prev_sum = '0;
        prev_c   = 1'b0;
        prev_o   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort no_done", 32'(done_out), 32'd0);
            chk("abort idle",    32'(ready_out), 32'd1);
        end
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0, "after_abort");

        // Randomized operations with occasional corner operands and idle gaps.
        for (int n = 0; n < 40; n++) begin
            logic [TW-1:0] ra, rb;
            int gap;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : TW'($urandom_range(0, 65535));
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : TW'($urandom_range(0, 65535));
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                scramble();
                tick();
                chk("gap idle", 32'(ready_out), 32'd1);
                chk("gap done", 32'(done_out),  32'd0);
                chk("gap sum",  32'(sum_out),   32'(prev_sum));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
